// File: rtl/mem_access_unit_if.sv
// Datapath-side request/response handshake plus the byte-lane memory port.
// The unit uses the slave view; the core/memory side uses the master view.
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic             halted;
  logic             req_valid;
  logic             req_write;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             req_ready;
  logic             stall;
  logic             resp_valid;
  logic [XLEN-1:0]  resp_rdata;
  logic             resp_err;
  logic [XLEN-1:0]  mem_addr;
  logic             mem_we;
  logic [3:0][7:0]  mem_data_in;
  logic [3:0][7:0]  mem_data_out;

  modport slave (
    input  halted, req_valid, req_write, req_addr, req_wdata, mem_data_out,
    output req_ready, stall, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_we, mem_data_in
  );

  modport master (
    output halted, req_valid, req_write, req_addr, req_wdata, mem_data_out,
    input  req_ready, stall, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_we, mem_data_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store controller: accepts one word access, stalls the core for
// LATENCY memory cycles, then pulses a response. Byte lanes are big-endian.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] rdata_word;
  logic            resp_valid;

  // Lane 0 carries the most significant byte in both directions.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bus.mem_data_in[gi]             = data_q[XLEN-1-8*gi -: 8];
    assign rdata_word[XLEN-1-8*gi -: 8]    = bus.mem_data_out[gi];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.halted) begin
          write_d = bus.req_write;
          // Misaligned requests skip memory entirely so mem_addr keeps its old value.
          if (bus.req_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            addr_d  = {bus.req_addr[XLEN-1:2], 2'b00};
            data_d  = bus.req_wdata;
            cnt_d   = CNT_INIT;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!write_q) rdata_d = rdata_word;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid     = (state_q == RESP);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_valid & err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.req_ready  = (state_q == IDLE) & ~bus.halted;
  assign bus.stall      = bus.req_valid & ~resp_valid;
  assign bus.mem_addr   = addr_q;
  // Decoded from registered state, so an asynchronous reset kills the strobe at once.
  assign bus.mem_we     = (state_q == ACCESS) && (cnt_q == 4'd0) && write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

  localparam int LAT  = 2;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b2, rst_b4;

  mem_access_unit_if #(.XLEN(32)) bus2 ();
  mem_access_unit_if #(.XLEN(32)) bus4 ();

  mem_access_unit #(.XLEN(32), .LATENCY(LAT)) dut2 (
    .clk   (clk),
    .rst_b (rst_b2),
    .bus   (bus2.slave)
  );

  mem_access_unit #(.XLEN(32), .LATENCY(LAT4)) dut4 (
    .clk   (clk),
    .rst_b (rst_b4),
    .bus   (bus4.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  init_bytes [256];
  logic [7:0]  mem_bytes  [256];
  logic [31:0] model_word [64];
  logic [31:0] model_rdata;
  logic [31:0] model_mem_addr;

  // Byte-addressed memory behind dut2 (upper address bits alias).
  always @(posedge clk) begin
    if (!rst_b2) begin
      for (int i = 0; i < 256; i++) mem_bytes[i] <= init_bytes[i];
    end else if (bus2.mem_we) begin
      for (int k = 0; k < 4; k++) mem_bytes[{bus2.mem_addr[7:2], 2'(k)}] <= bus2.mem_data_in[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) bus2.mem_data_out[k] = mem_bytes[{bus2.mem_addr[7:2], 2'(k)}];
  end

  always_comb bus4.mem_data_out = {8'hBE, 8'hBA, 8'hFE, 8'hCA};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    logic h;
    h = 1'($urandom_range(0, 1));
    bus2.req_valid = 1'b0;
    bus2.halted    = h;
    @(negedge clk);
    chk("idle_stall", 32'(bus2.stall), 32'd0);
    chk("idle_resp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("idle_mem_we", 32'(bus2.mem_we), 32'd0);
    chk("idle_req_ready", 32'(bus2.req_ready), 32'(!h));
    chk("idle_mem_addr", bus2.mem_addr, model_mem_addr);
    @(posedge clk); #1;
    bus2.halted = 1'b0;
  endtask

  // One access on dut2; cycle 0 is the acceptance cycle.
  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic hold_after, input logic rand_halt);
    logic aligned;
    int   r;
    logic exp_we;
    aligned = (addr % 4 == 0);
    r = aligned ? LAT + 1 : 1;
    bus2.halted    = 1'b0;
    bus2.req_valid = 1'b1;
    bus2.req_write = wr;
    bus2.req_addr  = addr;
    bus2.req_wdata = wd;
    for (int c = 0; c <= r; c++) begin
      if (c > 0) begin
        bus2.req_write = 1'($urandom);
        bus2.req_addr  = $urandom;
        bus2.req_wdata = $urandom;
        if (rand_halt) bus2.halted = 1'($urandom);
      end
      exp_we = aligned && wr && (c == LAT);
      if (aligned && c == 1) model_mem_addr = addr - (addr % 4);
      @(negedge clk);
      chk("req_ready", 32'(bus2.req_ready), 32'(c == 0));
      chk("stall", 32'(bus2.stall), 32'(c < r));
      chk("resp_valid", 32'(bus2.resp_valid), 32'(c == r));
      chk("mem_we", 32'(bus2.mem_we), 32'(exp_we));
      chk("mem_addr", bus2.mem_addr, model_mem_addr);
      if (exp_we) begin
        for (int k = 0; k < 4; k++)
          chk("mem_data_in_lane", 32'(bus2.mem_data_in[k]), (wd >> (24 - 8 * k)) & 32'hFF);
      end
      if (c == r) begin
        if (aligned && !wr) model_rdata = model_word[addr[7:2]];
        if (aligned && wr) model_word[addr[7:2]] = wd;
        chk("resp_rdata", bus2.resp_rdata, model_rdata);
        chk("resp_err", 32'(bus2.resp_err), 32'(!aligned));
      end
      @(posedge clk); #1;
    end
    bus2.req_valid = hold_after;
    bus2.halted    = 1'b0;
  endtask

  initial begin
    logic [31:0] a, w;
    logic        wr, hold;

    rst_b2 = 1'b0;
    rst_b4 = 1'b0;
    bus2.halted = 1'b0; bus2.req_valid = 1'b0; bus2.req_write = 1'b0;
    bus2.req_addr = '0; bus2.req_wdata = '0;
    bus4.halted = 1'b0; bus4.req_valid = 1'b0; bus4.req_write = 1'b0;
    bus4.req_addr = '0; bus4.req_wdata = '0;
    for (int i = 0; i < 256; i++) init_bytes[i] = 8'($urandom);
    init_bytes[0] = 8'hDE; init_bytes[1] = 8'hAD; init_bytes[2] = 8'hBE; init_bytes[3] = 8'hEF;
    for (int i = 0; i < 64; i++)
      model_word[i] = {init_bytes[4*i], init_bytes[4*i+1], init_bytes[4*i+2], init_bytes[4*i+3]};
    model_rdata    = '0;
    model_mem_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus2.resp_err), 32'd0);
    chk("rst_resp_rdata", bus2.resp_rdata, 32'd0);
    chk("rst_mem_addr", bus2.mem_addr, 32'd0);
    chk("rst_mem_data_in", 32'(bus2.mem_data_in), 32'd0);
    chk("rst_mem_we", 32'(bus2.mem_we), 32'd0);
    chk("rst_req_ready", 32'(bus2.req_ready), 32'd1);
    @(posedge clk); #1;
    rst_b2 = 1'b1;
    rst_b4 = 1'b1;
    idle_cycle();

    // Aligned load, aligned store, misaligned store, then back-to-back loads.
    do_access(1'b0, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
    idle_cycle();
    do_access(1'b1, 32'h0000_0204, 32'h1122_3344, 1'b0, 1'b0);
    idle_cycle();
    do_access(1'b1, 32'h0000_0102, 32'h5566_7788, 1'b0, 1'b0);
    idle_cycle();
    do_access(1'b0, 32'h0000_0000, 32'h0, 1'b1, 1'b0);
    do_access(1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b0);
    idle_cycle();
    do_access(1'b0, 32'h0000_0204, 32'h0, 1'b0, 1'b0);

    // Halted gating: a pending request must not be taken.
    bus2.halted    = 1'b1;
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b1;
    bus2.req_addr  = 32'h0000_0300;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("halt_req_ready", 32'(bus2.req_ready), 32'd0);
      chk("halt_mem_addr", bus2.mem_addr, model_mem_addr);
      chk("halt_resp_valid", 32'(bus2.resp_valid), 32'd0);
      chk("halt_mem_we", 32'(bus2.mem_we), 32'd0);
      @(posedge clk); #1;
    end
    bus2.halted    = 1'b0;
    bus2.req_valid = 1'b0;
    idle_cycle();

    // Randomized traffic with request scrambling and mid-access halts.
    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      w    = $urandom;
      wr   = 1'($urandom);
      hold = 1'($urandom);
      do_access(wr, a, w, hold, 1'b1);
      if (!hold) idle_cycle();
    end
    bus2.req_valid = 1'b0;
    idle_cycle();

    // Reset in the middle of a LATENCY=4 store.
    bus4.req_valid = 1'b1;
    bus4.req_write = 1'b1;
    bus4.req_addr  = 32'h0000_0040;
    bus4.req_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("r4_req_ready", 32'(bus4.req_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("r4_mem_addr", bus4.mem_addr, 32'h0000_0040);
    chk("r4_mem_we_c1", 32'(bus4.mem_we), 32'd0);
    @(posedge clk); #1;
    rst_b4 = 1'b0;
    #1;
    chk("r4_rst_resp_valid", 32'(bus4.resp_valid), 32'd0);
    chk("r4_rst_resp_err", 32'(bus4.resp_err), 32'd0);
    chk("r4_rst_resp_rdata", bus4.resp_rdata, 32'd0);
    chk("r4_rst_mem_addr", bus4.mem_addr, 32'd0);
    chk("r4_rst_mem_data_in", 32'(bus4.mem_data_in), 32'd0);
    chk("r4_rst_mem_we", 32'(bus4.mem_we), 32'd0);
    chk("r4_rst_req_ready", 32'(bus4.req_ready), 32'd1);
    bus4.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_b4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("r4_after_mem_we", 32'(bus4.mem_we), 32'd0);
      chk("r4_after_resp_valid", 32'(bus4.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus4.req_valid = 1'b1;
    bus4.req_write = 1'b0;
    bus4.req_addr  = 32'h0000_0080;
    for (int c = 0; c <= LAT4 + 1; c++) begin
      @(negedge clk);
      chk("r4_load_resp_valid", 32'(bus4.resp_valid), 32'(c == LAT4 + 1));
      chk("r4_load_stall", 32'(bus4.stall), 32'(c <= LAT4));
      chk("r4_load_mem_we", 32'(bus4.mem_we), 32'd0);
      if (c >= 1 && c <= LAT4) chk("r4_load_mem_addr", bus4.mem_addr, 32'h0000_0080);
      if (c == LAT4 + 1) begin
        chk("r4_load_rdata", bus4.resp_rdata, 32'hCAFE_BABE);
        chk("r4_load_err", 32'(bus4.resp_err), 32'd0);
      end
      @(posedge clk); #1;
    end
    bus4.req_valid = 1'b0;
    @(negedge clk);
    chk("r4_idle_ready", 32'(bus4.req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store controller between the single-cycle datapath and the byte-organised data memory. It accepts one word access from the datapath, holds the core with `stall` while the memory completes, then returns read data or write completion with a one-cycle response pulse. It drives the memory's 4×8-bit byte lanes in big-endian order.

## Interface
- `XLEN`, 32: address and data width; only 32 is supported.
- `LATENCY`, 2: memory access cycles per aligned request; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `halted`  in  1  core halted; no new request is accepted while high.
- `req_valid`  in  1  datapath requests an access; held high until the `resp_valid` cycle.
- `req_write`  in  1  1 = store, 0 = load; sampled at acceptance.
- `req_addr`  in  32  byte address (ALU result); sampled at acceptance.
- `req_wdata`  in  32  store data (rt value); sampled at acceptance.
- `req_ready`  out  1  high in IDLE when `halted` is 0.
- `stall`  out  1  `req_valid & ~resp_valid`; freezes the PC and register-file write.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load data; valid while `resp_valid` is high; holds its value until the next load completes.
- `resp_err`  out  1  misaligned-access flag; valid only with `resp_valid`.
- `mem_addr`  out  32  word address to memory, with bits [1:0] forced to 0.
- `mem_we`  out  1  memory write strobe.
- `mem_data_in`  out  4×8  bytes to memory; [0] = `wdata[31:24]` … [3] = `wdata[7:0]`.
- `mem_data_out`  in  4×8  bytes from memory; `rdata = {[0],[1],[2],[3]}`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready = ~halted`.
  - On `req_valid & req_ready`, latch `req_write`, `req_addr` and `req_wdata`.
  - If `req_addr[1:0] != 0`, go to RESP with the error flag set. There is no memory activity and `mem_we` stays 0.
  - Otherwise load the counter with `LATENCY-1` and go to ACCESS.
- ACCESS: `mem_addr` and `mem_data_in` are driven from the latched values, stable for every ACCESS cycle.
  - Counter decrements each cycle.
  - In the cycle where the counter is 0:
    - a store asserts `mem_we`, for exactly one cycle per access;
    - a load captures `mem_data_out` into `resp_rdata` at the end of that cycle.
  - Then go to RESP.
- RESP: `resp_valid = 1` and `resp_err` = latched error flag. Go unconditionally to IDLE. `req_valid` is ignored in this cycle.
- `req_valid` is ignored in ACCESS and RESP. Changes to the `req_*` inputs after acceptance have no effect.
- `halted` rising mid-access does not abort; the access completes normally.
- A misaligned store never writes memory. A misaligned load leaves `resp_rdata` unchanged.
- Outside ACCESS: `mem_addr` holds its last value and `mem_we = 0`.

## Timing
- Reset (async, immediate): state IDLE, counter 0, `resp_valid` 0, `resp_err` 0, `resp_rdata` 0, `mem_addr` 0, `mem_data_in` all 0, `mem_we` 0. `req_ready` is then 1 if `halted` is 0.
- Reset asserted during ACCESS drops `mem_we` combinationally in the same cycle; no partial write completes afterwards.
- Cycle 0 is the cycle in which the request is accepted.
  - Aligned request: ACCESS in cycles 1..`LATENCY`, `resp_valid` in cycle `LATENCY+1`, IDLE in cycle `LATENCY+2`.
  - Misaligned request: `resp_valid` in cycle 1.
- `stall` is high from cycle 0 through cycle `LATENCY`, and low in the RESP cycle so the core advances at that edge.
- Back-to-back accesses: the earliest next acceptance is cycle `LATENCY+2`, one idle cycle after RESP. Throughput is one access per `LATENCY+2` cycles.
- `resp_valid` is never high in two consecutive cycles.

## Test plan
- **Aligned load:** `LATENCY=2`, load at 0x100, memory returns bytes {0xDE,0xAD,0xBE,0xEF}. Require:
  - `mem_addr = 0x100` in cycles 1–2;
  - `resp_valid` in cycle 3 with `resp_rdata = 0xDEADBEEF`, `resp_err = 0`;
  - `stall` high in cycles 0–2.
- **Aligned store:** store 0x11223344 to 0x204. Require:
  - `mem_we` high only in cycle 2;
  - `mem_data_in = {0x11,0x22,0x33,0x44}`, `mem_addr = 0x204`;
  - `resp_valid` in cycle 3.
- **Misaligned access:** store to 0x102. Require:
  - `resp_valid = 1` and `resp_err = 1` in cycle 1;
  - `mem_we` never asserted;
  - `resp_rdata` unchanged.
- **Back-to-back loads:** load 0x0 then load 0x4 with `req_valid` held high throughout. Require second acceptance in cycle 4 and second `resp_valid` in cycle 7.
- **Reset mid-store:** with `LATENCY=4`, assert `rst_b = 0` in cycle 2. Require:
  - IDLE immediately, all outputs at reset values;
  - `mem_we` never high;
  - after release, a new load completes normally.
- **Halted gating:** with `halted = 1` and `req_valid = 1` for 5 cycles, require `req_ready = 0`, no `mem_addr` change, and `resp_valid = 0`.
